matrix_uart_sender: RTL and testbench
=====================================

MATRIX_UART_SENDER -- requirements
Module: matrix_uart_sender

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; bit period is CLK_FREQ/BAUD cycles, integer-truncated.
REQ-003 SHALL have these ports (clock and reset first); one clock, reset asynchronous active-low:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle request to send one matrix.
- i_base_addr  in  9  storage address of element (0,0).
- i_dim_m  in  3  row count, legal 1..5.
- i_dim_n  in  3  column count, legal 1..5.
- o_rd_addr  out  9  storage read address.
- i_rd_data  in  32  storage read data; valid one cycle after o_rd_addr is driven.
- uart_tx  out  1  serial line, 8N1, idle high.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse at job end.
- o_err  out  1  one-cycle pulse with o_done when the job was rejected.

Function
REQ-004 SHALL use an FSM with states IDLE, FETCH, WAIT, SEND_CHAR, SEND_SEP, SEND_CR, SEND_LF and DONE.
REQ-005 In IDLE, i_start=1 SHALL latch base address and dimensions, set o_busy the next cycle and go to FETCH; i_start is ignored while o_busy=1.
REQ-006 If latched m or n is 0 or greater than 5, the FSM SHALL go straight to DONE and pulse o_done and o_err together; no UART bits are sent.
REQ-007 Element (r,c) address SHALL be base + r*n + c, computed modulo 512 (9-bit wrap-around).
REQ-008 FETCH SHALL drive o_rd_addr; WAIT SHALL capture i_rd_data on the following cycle, giving a fixed read latency of 1 cycle.
REQ-009 SEND_CHAR SHALL transmit ASCII '0'+v when data v is 0..9, and ASCII '?' (0x3F) otherwise.
REQ-010 After each non-final column, SEND_SEP SHALL send a space (0x20); after the final column, SEND_CR (0x0D) and then SEND_LF (0x0A) SHALL be sent.
REQ-011 After the LF of row m-1, the FSM SHALL enter DONE, pulse o_done for one cycle, clear o_busy in the same cycle and return to IDLE.
REQ-012 The internal 8N1 serializer SHALL send 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), with each bit held exactly CLK_FREQ/BAUD cycles.
REQ-013 The next character SHALL start on the cycle after the previous stop bit ends; characters SHALL be back-to-back except for the 2-cycle fetch gap before each element.
REQ-014 Total characters per job SHALL be m*(2n+1), or m*(2n+1)+5 with the header of REQ-019.
REQ-015 o_rd_addr SHALL hold its last value outside FETCH.

Reset
REQ-016 rst_n=0 SHALL asynchronously force: state IDLE, uart_tx=1, o_busy=0, o_done=0, o_err=0, o_rd_addr=0, and clear all counters.
REQ-017 Reset asserted mid-character SHALL abort the frame immediately, with no completion of the stop bit; after release, the block SHALL stay idle until a new i_start.

Configuration
REQ-018 The macro MATRIX_UART_SENDER_HEADER_EN SHALL select the header feature.
REQ-019 With the macro defined, after start and before the first element the block SHALL send the header '0'+m, '*', '0'+n, CR, LF.
REQ-020 Without the macro, no header logic SHALL exist and the transmission SHALL begin with element (0,0).

Verification
REQ-021 Start with base=0, m=2, n=3, memory 1..6 -> line decodes as "1 2 3\r\n4 5 6\r\n"; o_done pulses once; o_err stays 0.
REQ-022 Start with m=0, n=3 -> o_done and o_err pulse together within 3 cycles; uart_tx stays high.
REQ-023 Start with base=510, m=1, n=3, memory[510]=7, memory[511]=8, memory[0]=9 -> "7 8 9\r\n" (address wrap).
REQ-024 Element value 12 at (0,0), m=n=1 -> "?\r\n"; a second i_start pulse while busy is ignored and produces exactly one o_done.
REQ-025 rst_n pulsed low during the data bits of the 2nd character -> uart_tx=1 at once; o_busy=0; no further characters until a new start.
REQ-026 With MATRIX_UART_SENDER_HEADER_EN defined, m=1, n=1, value 5 -> "1*1\r\n5\r\n"; each bit measured as 217 cycles at default parameters.

Source files
------------

// File: rtl/matrix_uart_sender.sv
// matrix_uart_sender: fetches an m x n matrix from storage and prints it as ASCII digits over an 8N1 UART.
// Optional header line "m*n\r\n" is built in when MATRIX_UART_SENDER_HEADER_EN is defined.
module matrix_uart_sender #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [8:0]  i_base_addr,
    input  logic [2:0]  i_dim_m,
    input  logic [2:0]  i_dim_n,
    output logic [8:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        uart_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    localparam int BIT = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(BIT + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT, SEND_CHAR, SEND_SEP, SEND_CR, SEND_LF, DONE
`ifdef MATRIX_UART_SENDER_HEADER_EN
        , SEND_HDR
`endif
    } state_t;

    state_t        r_state;
    logic [2:0]    r_m, r_n, r_row, r_col;
    logic [8:0]    r_addr, r_rd_addr;
    logic          r_bad, r_busy, r_done, r_err;
    logic          r_tx, r_ser_active;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_baud;
`ifdef MATRIX_UART_SENDER_HEADER_EN
    logic [1:0]    r_hdr_idx;
    logic          r_in_hdr;
`endif
    logic          w_ser_done, w_dims_ok, w_load, w_last_col;
    logic [7:0]    w_char;

    assign w_ser_done = r_ser_active && r_baud == CW'(BIT - 1) && r_bit == 4'd9;
    assign w_dims_ok  = i_dim_m != 3'd0 && i_dim_m <= 3'd5 && i_dim_n != 3'd0 && i_dim_n <= 3'd5;
    assign w_last_col = r_col == r_n - 3'd1;
    assign o_rd_addr  = r_rd_addr;
    assign uart_tx    = r_tx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

    // Pick the next character and the cycle it is handed to the serializer, so frames abut
    always_comb begin
        w_load = 1'b0;
        w_char = 8'h00;
        case (r_state)
            WAIT: begin
                w_load = 1'b1;
                w_char = (i_rd_data < 32'd10) ? 8'h30 + i_rd_data[7:0] : 8'h3F;
            end
            SEND_CHAR: begin
                w_load = w_ser_done;
                w_char = w_last_col ? 8'h0D : 8'h20;
            end
            SEND_CR: begin
                w_load = w_ser_done;
                w_char = 8'h0A;
            end
`ifdef MATRIX_UART_SENDER_HEADER_EN
            IDLE: begin
                w_load = i_start && w_dims_ok;
                w_char = 8'h30 + {5'd0, i_dim_m};
            end
            SEND_HDR: begin
                w_load = w_ser_done;
                w_char = (r_hdr_idx == 2'd0) ? 8'h2A : (r_hdr_idx == 2'd1) ? 8'h30 + {5'd0, r_n} : 8'h0D;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer FSM and 8N1 serializer; a load overrides the serializer's idle/advance step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_m          <= 3'd0;
            r_n          <= 3'd0;
            r_row        <= 3'd0;
            r_col        <= 3'd0;
            r_addr       <= 9'd0;
            r_rd_addr    <= 9'd0;
            r_bad        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_tx         <= 1'b1;
            r_ser_active <= 1'b0;
            r_shift      <= 9'h1FF;
            r_bit        <= 4'd0;
            r_baud       <= '0;
`ifdef MATRIX_UART_SENDER_HEADER_EN
            r_hdr_idx    <= 2'd0;
            r_in_hdr     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_load) begin
                r_tx         <= 1'b0;
                r_shift      <= {1'b1, w_char};
                r_bit        <= 4'd0;
                r_baud       <= '0;
                r_ser_active <= 1'b1;
            end else if (r_ser_active) begin
                if (r_baud == CW'(BIT - 1)) begin
                    r_baud <= '0;
                    if (r_bit == 4'd9) begin
                        r_ser_active <= 1'b0;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b1, r_shift[8:1]};
                        r_bit   <= r_bit + 4'd1;
                    end
                end else begin
                    r_baud <= r_baud + CW'(1);
                end
            end
            case (r_state)
                IDLE: if (i_start) begin
                    r_m    <= i_dim_m;
                    r_n    <= i_dim_n;
                    r_addr <= i_base_addr;
                    r_row  <= 3'd0;
                    r_col  <= 3'd0;
                    r_busy <= 1'b1;
                    r_bad  <= !w_dims_ok;
                    if (!w_dims_ok) begin
                        r_state <= DONE;
                    end else begin
`ifdef MATRIX_UART_SENDER_HEADER_EN
                        r_state   <= SEND_HDR;
                        r_hdr_idx <= 2'd0;
                        r_in_hdr  <= 1'b1;
`else
                        r_state   <= FETCH;
                        r_rd_addr <= i_base_addr;
`endif
                    end
                end
                FETCH: r_state <= WAIT;
                WAIT: r_state <= SEND_CHAR;
                SEND_CHAR: if (w_ser_done) r_state <= w_last_col ? SEND_CR : SEND_SEP;
                SEND_SEP: if (w_ser_done) begin
                    r_col     <= r_col + 3'd1;
                    r_addr    <= r_addr + 9'd1;
                    r_rd_addr <= r_addr + 9'd1;
                    r_state   <= FETCH;
                end
                SEND_CR: if (w_ser_done) r_state <= SEND_LF;
                SEND_LF: if (w_ser_done) begin
`ifdef MATRIX_UART_SENDER_HEADER_EN
                    if (r_in_hdr) begin
                        r_in_hdr  <= 1'b0;
                        r_rd_addr <= r_addr;
                        r_state   <= FETCH;
                    end else
`endif
                    if (r_row == r_m - 3'd1) begin
                        r_state <= DONE;
                    end else begin
                        r_row     <= r_row + 3'd1;
                        r_col     <= 3'd0;
                        r_addr    <= r_addr + 9'd1;
                        r_rd_addr <= r_addr + 9'd1;
                        r_state   <= FETCH;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_err   <= r_bad;
                    r_bad   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
`ifdef MATRIX_UART_SENDER_HEADER_EN
                SEND_HDR: if (w_ser_done) begin
                    r_hdr_idx <= r_hdr_idx + 2'd1;
                    if (r_hdr_idx == 2'd2) r_state <= SEND_CR;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_uart_sender.sv
// tb_matrix_uart_sender: directed tests for matrix_uart_sender with a UART line decoder.
module tb_matrix_uart_sender;
    localparam int BIT = 25_000_000 / 115200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [8:0]  i_base_addr = '0;
    logic [2:0]  i_dim_m = '0;
    logic [2:0]  i_dim_n = '0;
    logic [8:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic        uart_tx, o_busy, o_done, o_err;
    logic [31:0] mem [512];
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    matrix_uart_sender dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_dim_m(i_dim_m), .i_dim_n(i_dim_n), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .uart_tx(uart_tx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) i_rd_data <= mem[o_rd_addr];
    always @(negedge clk) if (rst_n) begin
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
    end

    function automatic string hdr(input int m, input int n);
`ifdef MATRIX_UART_SENDER_HEADER_EN
        return $sformatf("%0d*%0d\r\n", m, n);
`else
        return (m < 0 || n < 0) ? "?" : "";
`endif
    endfunction

    task automatic wait_fall(input int limit, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rx_char(output logic [7:0] ch, output int low_len, output bit ok);
        logic [9:0] bits;
        bit f, run;
        ch = 8'h00;
        low_len = 0;
        run = 1'b1;
        bits = '0;
        wait_fall(20 * BIT, f);
        ok = f;
        if (!f) return;
        for (int t = 0; t < 10 * BIT; t++) begin
            if (t % BIT == BIT / 2) bits[t / BIT] = uart_tx;
            if (run && uart_tx === 1'b0) low_len++;
            else run = 1'b0;
            @(negedge clk);
        end
        ch = bits[8:1];
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    endtask

    task automatic rx_check(input string exp, input string tag, output int first_len);
        logic [7:0] ch;
        int len;
        bit ok;
        first_len = 0;
        for (int i = 0; i < exp.len(); i++) begin
            rx_char(ch, len, ok);
            if (i == 0) first_len = len;
            vectors++;
            if (!ok || ch !== exp[i]) begin
                miscompares++;
                $display("FAIL %s char %0d: got 0x%02h (frame ok=%0d), need 0x%02h", tag, i, ch, ok, exp[i]);
                if (!ok) break;
            end
        end
    endtask

    task automatic start_job(input logic [8:0] base, input logic [2:0] m, input logic [2:0] n);
        @(negedge clk);
        i_base_addr = base;
        i_dim_m = m;
        i_dim_n = n;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int d0, input int e0);
        for (int t = 0; t < 50 && done_cnt == d0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL %s done pulses: got %0d, need 1", tag, done_cnt - d0);
        end
        vectors++;
        if (err_cnt !== e0) begin
            miscompares++;
            $display("FAIL %s err pulses: got %0d, need 0", tag, err_cnt - e0);
        end
        vectors++;
        if (o_busy !== 1'b0 || uart_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle after done: busy=%b tx=%b, need busy=0 tx=1", tag, o_busy, uart_tx);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset tx: got %b, need 1", uart_tx); end
        vectors++;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b, need 0", o_busy); end
        vectors++;
        if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b, need 0", o_done); end
        vectors++;
        if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b, need 0", o_err); end
        vectors++;
        if (o_rd_addr !== 9'd0) begin miscompares++; $display("FAIL reset rd_addr: got %0d, need 0", o_rd_addr); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int d0, e0, fl;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
        start_job(9'd0, 3'd2, 3'd3);
        vectors++;
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL basic busy after start: got %b, need 1", o_busy); end
        rx_check({hdr(2, 3), "1 2 3\r\n4 5 6\r\n"}, "basic", fl);
        finish_job("basic", d0, e0);
    endtask

    task automatic test_invalid;
        logic [2:0] ms [3] = '{3'd0, 3'd6, 3'd1};
        logic [2:0] ns [3] = '{3'd3, 3'd1, 3'd0};
        int d0, e0;
        bit both, tx_hi;
        for (int k = 0; k < 3; k++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            both = 1'b0;
            tx_hi = 1'b1;
            start_job(9'd0, ms[k], ns[k]);
            for (int t = 0; t < 3; t++) begin
                if (o_done === 1'b1 && o_err === 1'b1) both = 1'b1;
                if (uart_tx !== 1'b1) tx_hi = 1'b0;
                @(negedge clk);
            end
            repeat (3 * BIT) begin
                if (uart_tx !== 1'b1) tx_hi = 1'b0;
                @(negedge clk);
            end
            vectors++;
            if (!both) begin miscompares++; $display("FAIL invalid m=%0d n=%0d done+err: got none, need joint pulse", ms[k], ns[k]); end
            vectors++;
            if (!tx_hi) begin miscompares++; $display("FAIL invalid m=%0d n=%0d tx: got low, need high", ms[k], ns[k]); end
            vectors++;
            if (done_cnt - d0 !== 1 || err_cnt - e0 !== 1 || o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid m=%0d n=%0d counts: done=%0d err=%0d busy=%b, need 1 1 0", ms[k], ns[k], done_cnt - d0, err_cnt - e0, o_busy);
            end
        end
    endtask

    task automatic test_wrap;
        int d0, e0, fl;
        d0 = done_cnt;
        e0 = err_cnt;
        mem[510] = 32'd7;
        mem[511] = 32'd8;
        mem[0] = 32'd9;
        start_job(9'd510, 3'd1, 3'd3);
        rx_check({hdr(1, 3), "7 8 9\r\n"}, "wrap", fl);
        finish_job("wrap", d0, e0);
    endtask

    task automatic test_back_to_back;
        int d0, e0, fl;
        bit quiet;
        d0 = done_cnt;
        e0 = err_cnt;
        mem[20] = 32'd12;
        start_job(9'd20, 3'd1, 3'd1);
        fork
            rx_check({hdr(1, 1), "?\r\n"}, "wildcard", fl);
            begin
                repeat (3 * BIT) @(negedge clk);
                i_base_addr = 9'd0;
                i_dim_m = 3'd2;
                i_dim_n = 3'd3;
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        join
        vectors++;
        if (fl !== BIT) begin miscompares++; $display("FAIL bit time: got %0d cycles, need %0d", fl, BIT); end
        finish_job("wildcard", d0, e0);
        quiet = 1'b1;
        repeat (2 * BIT) begin
            if (uart_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (!quiet || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL ignored start: quiet=%0d done=%0d, need quiet=1 done=1", quiet, done_cnt - d0);
        end
    endtask

`ifdef MATRIX_UART_SENDER_HEADER_EN
    task automatic test_header;
        int d0, e0, fl;
        d0 = done_cnt;
        e0 = err_cnt;
        mem[40] = 32'd5;
        start_job(9'd40, 3'd1, 3'd1);
        rx_check("1*1\r\n5\r\n", "header", fl);
        vectors++;
        if (fl !== BIT) begin miscompares++; $display("FAIL header bit time: got %0d, need %0d", fl, BIT); end
        finish_job("header", d0, e0);
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0] ch;
        int len, d0;
        bit ok, quiet;
        mem[0] = 32'd5;
        d0 = done_cnt;
        start_job(9'd0, 3'd1, 3'd1);
        rx_char(ch, len, ok);
        wait_fall(20 * BIT, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midreset second char: got no start bit, need one"); end
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL midreset tx: got %b, need 1", uart_tx); end
        vectors++;
        if (o_busy !== 1'b0 || o_rd_addr !== 9'd0) begin
            miscompares++;
            $display("FAIL midreset state: busy=%b rd_addr=%0d, need 0 0", o_busy, o_rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20 * BIT) begin
            if (uart_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (!quiet || done_cnt !== d0) begin
            miscompares++;
            $display("FAIL midreset idle: quiet=%0d done=%0d, need quiet=1 done=0", quiet, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_wrap();
        test_back_to_back();
`ifdef MATRIX_UART_SENDER_HEADER_EN
        test_header();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
